// File: rtl/svo_stream_monitor_pkg.sv
// Shared definitions for the pixel stream monitor:
// FSM state encodings and the tuser start-of-frame bit.
package svo_stream_monitor_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } mon_state_e;

  localparam int SOF_BIT = 0;

endpackage

// File: rtl/svo_chan_sum.sv
// Per-channel running checksum, truncated to SUM_BITS,
// latched into sum_out when a frame closes.
module svo_chan_sum #(
  parameter int BPC      = 8,
  parameter int SUM_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                add,
  input  logic                close,
  input  logic [BPC-1:0]      din,
  output logic [SUM_BITS-1:0] sum_out
);

  logic [SUM_BITS-1:0] acc_q;
  logic [SUM_BITS-1:0] din_ext;

  assign din_ext = SUM_BITS'(din);

  // close and load share a cycle: old sum goes out, new frame starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      sum_out <= '0;
    end else begin
      if (load)
        acc_q <= din_ext;
      else if (add)
        acc_q <= acc_q + din_ext;
      if (close)
        sum_out <= acc_q;
    end
  end

endmodule

// File: rtl/svo_stream_monitor.sv
// Passive AXI-stream pixel monitor: per-frame counts, sums,
// stalls, geometry/protocol errors and a lock indicator.
module svo_stream_monitor
  import svo_stream_monitor_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int BPC      = 8,
  parameter int H_WIDTH  = 640,
  parameter int V_HEIGHT = 480,
  parameter int CNT_BITS = 24,
  parameter int SUM_BITS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mon_tvalid,
  input  logic                         mon_tready,
  input  logic [CHANNELS*BPC-1:0]      mon_tdata,
  input  logic                         mon_tuser,
  input  logic                         clear_err,
  output logic                         frame_done,
  output logic [CNT_BITS-1:0]          frame_pixels,
  output logic [CNT_BITS-1:0]          frame_stalls,
  output logic [CHANNELS*SUM_BITS-1:0] frame_sum,
  output logic [15:0]                  frame_count,
  output logic                         err_len,
  output logic                         err_proto,
  output logic                         locked
);

  localparam int DW = CHANNELS * BPC;
  localparam logic [CNT_BITS-1:0] FRAME_LEN =
    CNT_BITS'(H_WIDTH * V_HEIGHT);

  mon_state_e          state_q;
  logic [CNT_BITS-1:0] pix_q;
  logic [CNT_BITS-1:0] stall_q;
  logic                prev_valid_q;
  logic                prev_ready_q;
  logic                prev_user_q;
  logic [DW-1:0]       prev_data_q;
  logic                proto_q;
  logic                good_q;
  logic                err_len_d;
  logic                err_proto_d;

  logic sof, beat, open, close, add, stall;
  logic held, viol, len_bad, frame_good;

  always_comb begin
    sof        = mon_tuser;
    beat       = mon_tvalid && mon_tready;
    open       = beat && sof;
    close      = open && (state_q == IN_FRAME);
    add        = beat && !sof && (state_q == IN_FRAME);
    stall      = mon_tvalid && !mon_tready
                 && (state_q == IN_FRAME);
    held       = prev_valid_q && !prev_ready_q;
    viol       = held && (!mon_tvalid
                 || (mon_tdata != prev_data_q)
                 || (mon_tuser != prev_user_q));
    len_bad    = (pix_q != FRAME_LEN);
    frame_good = !len_bad && !proto_q && !viol;
    err_len_d  = (err_len && !clear_err)
                 || (close && len_bad);
    err_proto_d = (err_proto && !clear_err) || viol;
  end

  // saturating increments: add one unless already all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_SOF;
      pix_q        <= '0;
      stall_q      <= '0;
      prev_valid_q <= 1'b0;
      prev_ready_q <= 1'b0;
      prev_user_q  <= 1'b0;
      prev_data_q  <= '0;
      proto_q      <= 1'b0;
      good_q       <= 1'b0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      frame_stalls <= '0;
      frame_count  <= '0;
      err_len      <= 1'b0;
      err_proto    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      prev_valid_q <= mon_tvalid;
      prev_ready_q <= mon_tready;
      prev_user_q  <= mon_tuser;
      prev_data_q  <= mon_tdata;
      frame_done   <= close;
      err_len      <= err_len_d;
      err_proto    <= err_proto_d;
      if (open) begin
        state_q <= IN_FRAME;
        pix_q   <= CNT_BITS'(1);
        stall_q <= '0;
        proto_q <= 1'b0;
      end else if (state_q == IN_FRAME) begin
        if (add)
          pix_q <= pix_q + CNT_BITS'(~&pix_q);
        if (stall)
          stall_q <= stall_q + CNT_BITS'(~&stall_q);
        if (viol)
          proto_q <= 1'b1;
      end
      if (close) begin
        frame_pixels <= pix_q;
        frame_stalls <= stall_q;
        frame_count  <= frame_count + 16'd1;
        good_q       <= frame_good;
        locked       <= frame_good && good_q;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    svo_chan_sum #(
      .BPC      (BPC),
      .SUM_BITS (SUM_BITS)
    ) u_sum (
      .clk     (clk),
      .reset   (reset),
      .load    (open),
      .add     (add),
      .close   (close),
      .din     (mon_tdata[c*BPC +: BPC]),
      .sum_out (frame_sum[c*SUM_BITS +: SUM_BITS])
    );
  end

endmodule

// File: tb/tb_svo_stream_monitor.sv
// Scoreboard bench for svo_stream_monitor: directed frames,
// expected frame records queued, monitor pops on frame_done.
module tb_svo_stream_monitor;

  localparam int CH = 3;
  localparam int BPC = 8;
  localparam int CNTB = 8;
  localparam int SUMB = 8;

  typedef struct {
    int pix;
    int stalls;
    int sum;
    int cnt;
    bit el;
    bit ep;
    bit lk;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  logic tvalid = 0;
  logic tready = 0;
  logic [CH*BPC-1:0] tdata = '0;
  logic tuser = 0;
  logic clear_err = 0;
  logic frame_done;
  logic [CNTB-1:0] frame_pixels;
  logic [CNTB-1:0] frame_stalls;
  logic [CH*SUMB-1:0] frame_sum;
  logic [15:0] frame_count;
  logic err_len, err_proto, locked;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int pushes = 0;
  int dones = 0;

  always #5 clk = ~clk;

  svo_stream_monitor #(
    .CHANNELS (CH),
    .BPC      (BPC),
    .H_WIDTH  (4),
    .V_HEIGHT (2),
    .CNT_BITS (CNTB),
    .SUM_BITS (SUMB)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .mon_tvalid   (tvalid),
    .mon_tready   (tready),
    .mon_tdata    (tdata),
    .mon_tuser    (tuser),
    .clear_err    (clear_err),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .frame_stalls (frame_stalls),
    .frame_sum    (frame_sum),
    .frame_count  (frame_count),
    .err_len      (err_len),
    .err_proto    (err_proto),
    .locked       (locked)
  );

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push(int pix, int st, int s,
                      bit el, bit ep, bit lk);
    exp_t e;
    exp_cnt++;
    pushes++;
    e.pix = pix;
    e.stalls = st;
    e.sum = s;
    e.cnt = exp_cnt;
    e.el = el;
    e.ep = ep;
    e.lk = lk;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && frame_done) begin
      dones++;
      if (q.size() == 0) begin
        chk("unexpected frame_done", 1, 0);
      end else begin
        exp_t e;
        logic [7:0] s8;
        e = q.pop_front();
        s8 = e.sum[7:0];
        chk("frame_pixels", 64'(frame_pixels), 64'(e.pix));
        chk("frame_stalls", 64'(frame_stalls), 64'(e.stalls));
        chk("frame_sum", 64'(frame_sum), 64'({3{s8}}));
        chk("frame_count", 64'(frame_count), 64'(e.cnt));
        chk("err_len", 64'(err_len), 64'(e.el));
        chk("err_proto", 64'(err_proto), 64'(e.ep));
        chk("locked", 64'(locked), 64'(e.lk));
      end
    end
  end

  task automatic chk_zero();
    chk("rst frame_done", 64'(frame_done), 0);
    chk("rst frame_pixels", 64'(frame_pixels), 0);
    chk("rst frame_stalls", 64'(frame_stalls), 0);
    chk("rst frame_sum", 64'(frame_sum), 0);
    chk("rst frame_count", 64'(frame_count), 0);
    chk("rst err_len", 64'(err_len), 0);
    chk("rst err_proto", 64'(err_proto), 0);
    chk("rst locked", 64'(locked), 0);
  endtask

  // mode 0: pixel index, 1: 0xFF, 2: zero
  task automatic send_frame(int n, int mode, int st_at,
                            int st_len, bit corrupt,
                            int clr_at);
    for (int i = 0; i < n; i++) begin
      logic [7:0] px;
      px = (mode == 0) ? 8'(i) :
           (mode == 1) ? 8'hFF : 8'h00;
      if (i == st_at && st_len > 0) begin
        tvalid = 1;
        tready = 0;
        tdata = {3{px}};
        tuser = (i == 0);
        for (int s = 0; s < st_len; s++) begin
          if (corrupt && s == 1) begin
            chk("err_proto before", 64'(err_proto), 0);
            tdata = {3{px ^ 8'h5A}};
          end
          @(posedge clk);
          #1;
          if (corrupt && s == 1)
            chk("err_proto rise", 64'(err_proto), 1);
        end
      end
      if (i == clr_at)
        chk("err_len set", 64'(err_len), 1);
      clear_err = (i == clr_at);
      tvalid = 1;
      tready = 1;
      tdata = {3{px}};
      tuser = (i == 0);
      @(posedge clk);
      #1;
      clear_err = 0;
      if (i == clr_at)
        chk("err_len cleared", 64'(err_len), 0);
    end
  endtask

  task automatic idle(int n);
    tvalid = 0;
    tready = 1;
    tuser = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("scoreboard drained", 64'(q.size()), 0);
  endtask

  initial begin
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk_zero();
    rst = 0;

    send_frame(8, 0, -1, 0, 0, -1);
    push(8, 0, 28, 0, 0, 0);
    send_frame(8, 0, -1, 0, 0, -1);
    push(8, 0, 28, 0, 0, 1);
    send_frame(8, 0, -1, 0, 0, -1);
    push(8, 0, 28, 0, 0, 1);
    send_frame(7, 0, -1, 0, 0, -1);
    push(7, 0, 21, 1, 0, 0);
    send_frame(8, 0, -1, 0, 0, 2);
    push(8, 0, 28, 0, 0, 0);
    send_frame(8, 0, 4, 5, 0, -1);
    push(8, 5, 28, 0, 0, 1);
    send_frame(8, 0, 4, 3, 1, -1);
    push(8, 3, 28, 0, 1, 0);
    send_frame(8, 0, -1, 0, 0, -1);
    push(8, 0, 28, 0, 1, 0);
    send_frame(8, 1, -1, 0, 0, -1);
    push(8, 0, 8'hF8, 0, 1, 1);
    send_frame(300, 2, -1, 0, 0, -1);
    push(255, 0, 0, 1, 1, 0);
    send_frame(3, 0, -1, 0, 0, -1);
    drain();

    tvalid = 0;
    rst = 1;
    exp_cnt = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk_zero();
    rst = 0;

    for (int i = 0; i < 5; i++) begin
      tvalid = 1;
      tready = 1;
      tuser = 0;
      tdata = {3{8'(i + 3)}};
      @(posedge clk);
      #1;
    end
    send_frame(8, 0, -1, 0, 0, -1);
    push(8, 0, 28, 0, 0, 0);
    send_frame(8, 0, -1, 0, 0, -1);
    push(8, 0, 28, 0, 0, 1);
    send_frame(1, 0, -1, 0, 0, -1);
    idle(3);
    drain();
    chk("frame_done total", 64'(dones), 64'(pushes));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
